// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, operation encoding and mstatus/interrupt bit positions
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  typedef enum logic [1:0] {CSR_NONE, CSR_WRITE, CSR_CLEAR, CSR_SET} csr_op_t;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_BASE     = 16;
endpackage

// File: rtl/csr_counter.sv
// csr_counter: free-running counter with independently writable 32-bit halves
module csr_counter #(
  parameter int COUNTER_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [31:0]          wdata_i,
  output logic [COUNTER_W-1:0] count_o
);
  if (COUNTER_W == 64) begin : g_64
    always_ff @(posedge clk_i)
      if (!rst_ni) count_o <= '0;
      else if (wr_lo_i || wr_hi_i) begin
        if (wr_lo_i) count_o[31:0] <= wdata_i;
        if (wr_hi_i) count_o[COUNTER_W-1:32] <= wdata_i;
      end else if (inc_i) count_o <= count_o + COUNTER_W'(1);
  end else begin : g_32
    // the high-half address is accepted but has nothing to hold
    always_ff @(posedge clk_i)
      if (!rst_ni) count_o <= '0;
      else if (wr_lo_i) count_o <= wdata_i;
      else if (inc_i) count_o <= count_o + COUNTER_W'(1);
  end
endmodule

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with trap/mret stacking, interrupt prioritisation and counters
module csr_file_m
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter int          COUNTER_W   = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [2:0]         csr_op_i,
  input  logic [11:0]        addr_i,
  input  logic [31:0]        write_data_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        mcause_i,
  input  logic               mret_i,
  input  logic               instr_retire_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [31:0]        read_data_o,
  output logic               illegal_o,
  output logic [31:0]        mie_o,
  output logic [31:0]        mtvec_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        trap_pc_o,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o
);
  localparam logic [31:0] MIE_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);
  logic [31:0] mscratch_q, mcause_q, mip_w, csr_rd, wdata, pend;
  logic [NUM_IRQ-1:0] mip_q;
  logic [COUNTER_W-1:0] cyc, ret;
  logic [63:0] cyc64, ret64;
  logic mie_b, mpie_b, trap, hit, we;
  csr_op_t op;
  assign op    = csr_op_t'(csr_op_i[1:0]);
  assign trap  = csr_op_i[2];
  assign mip_w = 32'(mip_q) << IRQ_BASE;
  assign cyc64 = 64'(cyc);
  assign ret64 = 64'(ret);
  always_comb begin
    hit    = 1'b1;
    csr_rd = '0;
    case (addr_i)
      CSR_MSTATUS:   csr_rd = 32'h1800 | (32'(mpie_b) << MSTATUS_MPIE) | (32'(mie_b) << MSTATUS_MIE);
      CSR_MIE:       csr_rd = mie_o;
      CSR_MTVEC:     csr_rd = mtvec_o;
      CSR_MSCRATCH:  csr_rd = mscratch_q;
      CSR_MEPC:      csr_rd = mepc_o;
      CSR_MCAUSE:    csr_rd = mcause_q;
      CSR_MIP:       csr_rd = mip_w;
      CSR_MCYCLE:    csr_rd = cyc64[31:0];
      CSR_MCYCLEH:   csr_rd = cyc64[63:32];
      CSR_MINSTRET:  csr_rd = ret64[31:0];
      CSR_MINSTRETH: csr_rd = ret64[63:32];
      CSR_MHARTID:   csr_rd = '0;
      default:       hit = 1'b0;
    endcase
  end
  // a trap owns the cycle, so the CSR field is neither checked nor applied
  assign illegal_o   = op != CSR_NONE && !trap && (!hit || addr_i[11:10] == 2'b11);
  assign we          = op != CSR_NONE && !trap && !mret_i && !illegal_o;
  assign wdata       = op == CSR_WRITE ? write_data_i : op == CSR_CLEAR ? csr_rd & ~write_data_i : csr_rd | write_data_i;
  assign read_data_o = illegal_o ? '0 : csr_rd;
  assign pend        = mie_o & mip_w;
  assign irq_req_o   = mie_b && |pend;
  assign trap_pc_o   = {mtvec_o[31:2], 2'b00} + (mtvec_o[0] && mcause_i[31] ? mcause_i << 2 : 32'h0);
  always_comb begin
    irq_cause_o = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--)
      if (pend[IRQ_BASE+k]) irq_cause_o = {1'b1, 31'(IRQ_BASE + k)};
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      mie_b      <= 1'b0;
      mpie_b     <= 1'b0;
      mie_o      <= '0;
      mtvec_o    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_o     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
    end else begin
      mip_q <= irq_i;
      if (trap) begin
        mepc_o   <= pc_i & ~32'h3;
        mcause_q <= mcause_i;
        mpie_b   <= mie_b;
        mie_b    <= 1'b0;
      end else if (mret_i) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
      end else if (we)
        case (addr_i)
          CSR_MSTATUS: begin
            mie_b  <= wdata[MSTATUS_MIE];
            mpie_b <= wdata[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_o <= wdata & MIE_MASK;
          CSR_MTVEC:    mtvec_o <= {wdata[31:2], 1'b0, VECTORED_EN && wdata[0]};
          CSR_MSCRATCH: mscratch_q <= wdata;
          CSR_MEPC:     mepc_o <= wdata & ~32'h3;
          CSR_MCAUSE:   mcause_q <= wdata;
          default: ;
        endcase
    end
  csr_counter #(.COUNTER_W(COUNTER_W)) u_mcycle (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(1'b1),
    .wr_lo_i(we && addr_i == CSR_MCYCLE), .wr_hi_i(we && addr_i == CSR_MCYCLEH),
    .wdata_i(wdata), .count_o(cyc)
  );
  csr_counter #(.COUNTER_W(COUNTER_W)) u_minstret (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(instr_retire_i),
    .wr_lo_i(we && addr_i == CSR_MINSTRET), .wr_hi_i(we && addr_i == CSR_MINSTRETH),
    .wdata_i(wdata), .count_o(ret)
  );
endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed and randomized checks of csr_file_m against a behavioural model
module tb_csr_file_m;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [2:0] csr_op_i = '0;
  logic [11:0] addr_i = '0;
  logic [31:0] write_data_i = '0, pc_i = '0, mcause_i = '0;
  logic mret_i = 1'b0, instr_retire_i = 1'b0;
  logic [15:0] irq_i = '0;
  logic [31:0] read_data_o, mie_o, mtvec_o, mepc_o, trap_pc_o, irq_cause_o;
  logic illegal_o, irq_req_o;
  int n_cmp = 0, n_err = 0;
  logic m_mieb, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cyc, m_ret;
  logic [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h123, 12'h7C0};

  csr_file_m #(.NUM_IRQ(16), .COUNTER_W(64), .VECTORED_EN(1'b1), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_op_i(csr_op_i), .addr_i(addr_i),
    .write_data_i(write_data_i), .pc_i(pc_i), .mcause_i(mcause_i), .mret_i(mret_i),
    .instr_retire_i(instr_retire_i), .irq_i(irq_i), .read_data_o(read_data_o),
    .illegal_o(illegal_o), .mie_o(mie_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .trap_pc_o(trap_pc_o), .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mieb ? 32'h8 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [2:0] op, input logic [11:0] a);
    bit impl = a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    return op[1:0] != 2'd0 && !op[2] && (!impl || a[11:10] == 2'b11);
  endfunction

  function automatic logic [31:0] m_cause();
    for (int k = 16; k < 32; k++) if (m_mie[k] && m_mip[k]) return 32'h8000_0000 + 32'(k);
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_trap_pc(input logic [31:0] mc);
    return (m_mtvec & ~32'h3) + ((m_mtvec[0] && mc[31]) ? (mc & 32'h7FFF_FFFF) * 4 : 32'h0);
  endfunction

  task automatic m_clock();
    logic [31:0] r, v;
    logic [63:0] nc, nr;
    bit wr;
    if (!rst_ni) begin
      {m_mieb, m_mpie} = '0;
      {m_mie, m_mscratch, m_mepc, m_mcause, m_mip} = '0;
      m_mtvec = MTVEC_RST;
      m_cyc = 0;
      m_ret = 0;
      return;
    end
    r  = m_read(addr_i);
    wr = csr_op_i[1:0] != 0 && !csr_op_i[2] && !mret_i && !m_illegal(csr_op_i, addr_i);
    v  = csr_op_i[1:0] == 2'd1 ? write_data_i : csr_op_i[1:0] == 2'd2 ? r & ~write_data_i : r | write_data_i;
    nc = m_cyc + 1;
    nr = m_ret + (instr_retire_i ? 1 : 0);
    if (wr && addr_i == 12'hB00) nc = {m_cyc[63:32], v};
    if (wr && addr_i == 12'hB80) nc = {v, m_cyc[31:0]};
    if (wr && addr_i == 12'hB02) nr = {m_ret[63:32], v};
    if (wr && addr_i == 12'hB82) nr = {v, m_ret[31:0]};
    if (csr_op_i[2]) begin
      m_mepc = pc_i & ~32'h3;
      m_mcause = mcause_i;
      m_mpie = m_mieb;
      m_mieb = 1'b0;
    end else if (mret_i) begin
      m_mieb = m_mpie;
      m_mpie = 1'b1;
    end else if (wr) begin
      if (addr_i == 12'h300) begin m_mieb = v[3]; m_mpie = v[7]; end
      if (addr_i == 12'h304) m_mie = v & 32'hFFFF_0000;
      if (addr_i == 12'h305) m_mtvec = v & ~32'h2;
      if (addr_i == 12'h340) m_mscratch = v;
      if (addr_i == 12'h341) m_mepc = v & ~32'h3;
      if (addr_i == 12'h342) m_mcause = v;
    end
    m_mip = {irq_i, 16'h0};
    m_cyc = nc;
    m_ret = nr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    m_clock();
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_op_i = op;
    addr_i = a;
    write_data_i = wd;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    foreach (addrs[i]) begin
      drive(3'd0, addrs[i], 32'h0);
      n_cmp++; if (read_data_o !== m_read(addrs[i])) begin n_err++; $display("FAIL reset_read %h: got %h want %h", addrs[i], read_data_o, m_read(addrs[i])); end
    end
    drive(3'd0, 12'h300, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0000_1800) begin n_err++; $display("FAIL reset_mstatus: got %h want 00001800", read_data_o); end
    drive(3'd0, 12'h305, 32'h0);
    n_cmp++; if (read_data_o !== MTVEC_RST) begin n_err++; $display("FAIL reset_mtvec: got %h want %h", read_data_o, MTVEC_RST); end
    n_cmp++; if (irq_req_o !== 1'b0 || irq_cause_o !== 32'h0) begin n_err++; $display("FAIL reset_irq: got %b/%h want 0/0", irq_req_o, irq_cause_o); end
    n_cmp++; if (trap_pc_o !== 32'h8000_0100) begin n_err++; $display("FAIL reset_trap_pc: got %h want 80000100", trap_pc_o); end
    drive(3'd3, 12'h123, 32'h0);
    n_cmp++; if (illegal_o !== 1'b1 || read_data_o !== 32'h0) begin n_err++; $display("FAIL unimpl_access: got %b/%h want 1/0", illegal_o, read_data_o); end
  endtask

  task automatic test_rw();
    drive(3'd1, 12'h340, 32'hF0F0_F0F0); tick();
    drive(3'd2, 12'h340, 32'h0000_00F0); tick();
    drive(3'd3, 12'h340, 32'h0000_000F); tick();
    drive(3'd0, 12'h340, 32'h0);
    n_cmp++; if (read_data_o !== 32'hF0F0_F00F) begin n_err++; $display("FAIL mscratch_rmw: got %h want F0F0F00F", read_data_o); end
    drive(3'd1, 12'hF14, 32'hDEAD_BEEF);
    n_cmp++; if (illegal_o !== 1'b1) begin n_err++; $display("FAIL mhartid_illegal: got %b want 1", illegal_o); end
    tick();
    drive(3'd0, 12'hF14, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0 || illegal_o !== 1'b0) begin n_err++; $display("FAIL mhartid_read: got %h/%b want 0/0", read_data_o, illegal_o); end
  endtask

  task automatic test_irq();
    drive(3'd1, 12'h300, 32'h8); tick();
    drive(3'd1, 12'h304, 32'h0002_0000); tick();
    irq_i = 16'h0002;
    drive(3'd0, 12'h0, 32'h0);
    n_cmp++; if (irq_req_o !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b want 0", irq_req_o); end
    tick();
    n_cmp++; if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0011) begin n_err++; $display("FAIL irq_req: got %b/%h want 1/80000011", irq_req_o, irq_cause_o); end
    drive(3'd1, 12'h304, 32'hFFFF_FFFF); tick();
    n_cmp++; if (mie_o !== 32'hFFFF_0000) begin n_err++; $display("FAIL mie_warl: got %h want FFFF0000", mie_o); end
    irq_i = 16'h8004;
    drive(3'd0, 12'h0, 32'h0); tick();
    n_cmp++; if (irq_cause_o !== 32'h8000_0012) begin n_err++; $display("FAIL irq_priority: got %h want 80000012", irq_cause_o); end
    irq_i = 16'h0;
  endtask

  task automatic test_trap();
    drive(3'd1, 12'h305, 32'h1000_0003); tick();
    n_cmp++; if (mtvec_o !== 32'h1000_0001) begin n_err++; $display("FAIL mtvec_warl: got %h want 10000001", mtvec_o); end
    mcause_i = 32'h8000_0011;
    pc_i = 32'h0000_0203;
    drive(3'b100, 12'h0, 32'h0);
    n_cmp++; if (trap_pc_o !== 32'h1000_0044) begin n_err++; $display("FAIL trap_pc_vec: got %h want 10000044", trap_pc_o); end
    tick();
    drive(3'd0, 12'h300, 32'h0);
    n_cmp++; if (mepc_o !== 32'h0000_0200 || read_data_o !== 32'h0000_1880) begin n_err++; $display("FAIL trap_entry: got %h/%h want 00000200/00001880", mepc_o, read_data_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    drive(3'd0, 12'h300, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0000_1888) begin n_err++; $display("FAIL mret: got %h want 00001888", read_data_o); end
    mcause_i = 32'h0000_0002;
    drive(3'b101, 12'h340, 32'h1234_5678);
    n_cmp++; if (trap_pc_o !== 32'h1000_0000) begin n_err++; $display("FAIL trap_pc_exc: got %h want 10000000", trap_pc_o); end
    tick();
    drive(3'd0, 12'h340, 32'h0);
    n_cmp++; if (read_data_o !== 32'hF0F0_F00F) begin n_err++; $display("FAIL trap_blocks_write: got %h want F0F0F00F", read_data_o); end
    drive(3'd0, 12'h342, 32'h0);
    n_cmp++; if (read_data_o !== 32'h2) begin n_err++; $display("FAIL mcause: got %h want 00000002", read_data_o); end
  endtask

  task automatic test_counter();
    drive(3'd1, 12'hB00, 32'hFFFF_FFFF); tick();
    drive(3'd1, 12'hB80, 32'h0); tick();
    drive(3'd0, 12'hB00, 32'h0);
    n_cmp++; if (read_data_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mcycle_hold: got %h want FFFFFFFF", read_data_o); end
    tick();
    drive(3'd0, 12'hB00, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0) begin n_err++; $display("FAIL mcycle_wrap: got %h want 00000000", read_data_o); end
    drive(3'd0, 12'hB80, 32'h0);
    n_cmp++; if (read_data_o !== 32'h1) begin n_err++; $display("FAIL mcycleh_carry: got %h want 00000001", read_data_o); end
    instr_retire_i = 1'b1;
    repeat (3) tick();
    instr_retire_i = 1'b0;
    drive(3'd0, 12'hB02, 32'h0);
    n_cmp++; if (read_data_o !== m_ret[31:0]) begin n_err++; $display("FAIL minstret: got %h want %h", read_data_o, m_ret[31:0]); end
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    drive(3'd0, 12'hB00, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0) begin n_err++; $display("FAIL mcycle_reset: got %h want 00000000", read_data_o); end
    drive(3'd0, 12'hB80, 32'h0);
    n_cmp++; if (read_data_o !== 32'h0) begin n_err++; $display("FAIL mcycleh_reset: got %h want 00000000", read_data_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 3));
      op[2] = $urandom_range(0, 15) == 0;
      mret_i = !op[2] && $urandom_range(0, 15) == 0;
      instr_retire_i = 1'($urandom);
      irq_i = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0;
      pc_i = $urandom;
      mcause_i = {1'($urandom), 26'h0, 5'($urandom)};
      drive(op, addrs[$urandom_range(0, 13)], $urandom);
      n_cmp++; if (read_data_o !== (m_illegal(op, addr_i) ? 32'h0 : m_read(addr_i))) begin n_err++; $display("FAIL rnd_read %0d @%h: got %h want %h", i, addr_i, read_data_o, m_read(addr_i)); end
      n_cmp++; if (illegal_o !== m_illegal(op, addr_i)) begin n_err++; $display("FAIL rnd_illegal %0d: got %b want %b", i, illegal_o, m_illegal(op, addr_i)); end
      n_cmp++; if (irq_req_o !== (m_mieb && (m_mie & m_mip) != 0)) begin n_err++; $display("FAIL rnd_irq_req %0d: got %b", i, irq_req_o); end
      n_cmp++; if (irq_cause_o !== m_cause()) begin n_err++; $display("FAIL rnd_irq_cause %0d: got %h want %h", i, irq_cause_o, m_cause()); end
      n_cmp++; if (trap_pc_o !== m_trap_pc(mcause_i)) begin n_err++; $display("FAIL rnd_trap_pc %0d: got %h want %h", i, trap_pc_o, m_trap_pc(mcause_i)); end
      n_cmp++; if ({mie_o, mtvec_o, mepc_o} !== {m_mie, m_mtvec, m_mepc}) begin n_err++; $display("FAIL rnd_regs %0d: got %h %h %h want %h %h %h", i, mie_o, mtvec_o, mepc_o, m_mie, m_mtvec, m_mepc); end
      tick();
    end
    mret_i = 1'b0;
    instr_retire_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rw();
    test_irq();
    test_trap();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file; successor to the basic five-register CSR unit.
- Adds mstatus interrupt-enable stacking (trap/mret), a registered interrupt-pending array with NUM_IRQ platform lines, and prioritised interrupt request generation.
- Adds vectored/direct mtvec target computation, mcycle/minstret counters and illegal-access detection.
- Sits beside the decoder/LSU in the core; the control unit drives csr_op_i and mret_i, and consumes trap_pc_o and irq_req_o.

Parameters:
- NUM_IRQ, 16, platform interrupt lines mapped to mie/mip bits 16..16+NUM_IRQ-1; legal range 1..16.
- COUNTER_W, 64, mcycle/minstret width; legal values 32 or 64.
- VECTORED_EN, 1, permits mtvec MODE=1; when 0, MODE is forced to 0.
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- csr_op_i  in  3  [1:0]: 0 none, 1 write, 2 clear, 3 set; [2]: trap entry
- addr_i  in  12  CSR address
- write_data_i  in  32  CSR operand (rs1 or zimm)
- pc_i  in  32  PC of the trapping instruction
- mcause_i  in  32  cause value for trap entry
- mret_i  in  1  mret executes this cycle
- instr_retire_i  in  1  one instruction retires this cycle
- irq_i  in  NUM_IRQ  level-sensitive platform interrupts
- read_data_o  out  32  combinational read of addr_i
- illegal_o  out  1  illegal CSR access this cycle
- mie_o  out  32  mie register
- mtvec_o  out  32  mtvec register
- mepc_o  out  32  mepc register
- trap_pc_o  out  32  trap target for the current mcause_i
- irq_req_o  out  1  enabled interrupt is pending
- irq_cause_o  out  32  cause value for the highest-priority pending interrupt

Behaviour:
- Implemented CSRs:
  - 0x300 mstatus: MIE bit 3, MPIE bit 7; MPP[12:11] reads 2'b11; all other bits read 0.
  - 0x304 mie: only bits 16..16+NUM_IRQ-1 are writable.
  - 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
  - 0x344 mip: read-only.
  - 0xB00/0xB80 mcycle/mcycleh, 0xB02/0xB82 minstret/minstreth.
  - 0xF14 mhartid: reads 0.
- Write data: op1 = operand; op2 = read & ~operand; op3 = read | operand. Writes take effect at posedge clk_i; reads are combinational with 0-cycle latency.
- WARL fields:
  - mepc[1:0] is forced to 0.
  - mtvec[1] is forced to 0; mtvec[0] is forced to 0 when VECTORED_EN=0.
- illegal_o is asserted combinationally when csr_op_i[1:0]!=0 and either addr_i is unimplemented or addr_i[11:10]==2'b11 (read-only). An illegal access changes no state; read_data_o=0.
- Priority when events coincide: trap (csr_op_i[2]) > mret_i > CSR write.
- Trap: mepc<=pc_i&~3, mcause<=mcause_i, MPIE<=MIE, MIE<=0. The CSR write field and illegal check are ignored that cycle.
- mret: MIE<=MPIE, MPIE<=1.
- mip: irq_i is registered into mip[16+k] every cycle (1-cycle latency).
- irq_req_o = MIE & |(mip & mie), combinational from registered state.
- irq_cause_o = {1'b1, 31'(16+k)}, where k is the lowest pending and enabled index; it is 0 when nothing is pending.
- trap_pc_o:
  - base = {mtvec[31:2],2'b00}.
  - If mtvec[0]=1 and mcause_i[31]=1: base + (mcause_i[30:0]<<2).
  - Otherwise: base.
- Counters:
  - mcycle increments every cycle; minstret increments when instr_retire_i=1.
  - A CSR write to either half replaces that half and suppresses the increment for that cycle. The other half holds.
  - Low-half carry propagates into the high half.
  - Both counters wrap to 0 at all-ones.
  - With COUNTER_W=32, the h addresses read 0, are writable and have no effect.
- Reset (rst_ni=0 at posedge): mstatus=0, mie=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mip=0, counters=0.
  - Reset overrides a trap or write in the same cycle.
  - Outputs immediately after reset: irq_req_o=0, irq_cause_o=0, trap_pc_o=MTVEC_RESET&~3.

Decomposition:
- csr_pkg holds:
  - CSR address localparams.
  - The csr_op_t enum (NONE/WRITE/CLEAR/SET).
  - mstatus bit positions (MIE=3, MPIE=7).
  - IRQ_BASE=16.
- One sub-module, csr_counter #(COUNTER_W): holds inc_i, wr_lo_i, wr_hi_i and wdata_i, and outputs the count. It is instantiated for mcycle and for minstret.

Test Plan:
- Reset, then read every implemented CSR -> mtvec=MTVEC_RESET, mstatus reads 0x0000_1800, all others 0; read 0x123 -> illegal_o=1, read_data_o=0.
- mscratch write 0xF0F0_F0F0, clear with 0x0000_00F0, set with 0x0000_000F -> reads 0xF0F0_F00F; write 0xDEAD_BEEF to 0xF14 -> illegal_o=1, mhartid stays 0.
- mstatus.MIE=1, mie[17]=1, irq_i[1]=1 -> irq_req_o=1 one cycle later, irq_cause_o=0x8000_0011.
- With mtvec=0x1000_0001, trap with mcause_i=0x8000_0011 and pc_i=0x200 -> trap_pc_o=0x1000_0044 in the same cycle; after the edge mepc=0x200, MIE=0, MPIE=1. mret -> MIE=1.
- With mtvec=0x1000_0001, trap with mcause_i=0x0000_0002 -> trap_pc_o=0x1000_0000. Trap and mscratch write in the same cycle -> mscratch unchanged.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> two cycles later mcycle=0x0000_0000 and mcycleh=1. Assert rst_ni=0 mid-count -> both halves read 0.
